// File: rtl/multdiv_pkg.sv
`default_nettype none
// =============================================================================
// Module   : multdiv_pkg
// Brief    : Shared types and latency helpers for the multdiv_n datapath.
// Revision : 1.0  initial release
// =============================================================================
package multdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_sel_e;

  // Start-to-ready latencies; the two trailing cycles are FIX and DONE.
  localparam int FIX_DONE_CYCLES = 2;
  localparam int DIVZERO_LATENCY = 1;

  function automatic int mult_latency(input int width);
    return width / 2 + FIX_DONE_CYCLES;
  endfunction

  function automatic int div_latency(input int width);
    return width + FIX_DONE_CYCLES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_radix4_enc.sv
`default_nettype none
// =============================================================================
// Module   : booth_radix4_enc
// Brief    : Radix-4 Booth digit select from a 3-bit multiplier window.
// Revision : 1.0  initial release
// =============================================================================
module booth_radix4_enc
  import multdiv_pkg::*;
(
  input  logic [2:0] window,
  output booth_sel_e sel
);

  always_comb begin
    sel = BOOTH_ZERO;
    case (window)
      3'b001, 3'b010: sel = BOOTH_POS1;
      3'b011:         sel = BOOTH_POS2;
      3'b100:         sel = BOOTH_NEG2;
      3'b101, 3'b110: sel = BOOTH_NEG1;
      default:        sel = BOOTH_ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_n.sv
`default_nettype none
// =============================================================================
// Module   : multdiv_n
// Brief    : Iterative multiplier (radix-4 Booth) / non-restoring divider,
//            signed or unsigned. Macro MULTDIV_N_HI_RESULT_EN enables the
//            high-word / remainder output.
// Revision : 1.0  initial release
// =============================================================================
module multdiv_n
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int PW         = 2 * WIDTH;
  localparam int RW         = WIDTH + 2;
  localparam int CW         = $clog2(WIDTH);
  localparam int MULT_ITERS = mult_latency(WIDTH) - FIX_DONE_CYCLES;
  localparam int DIV_ITERS  = div_latency(WIDTH) - FIX_DONE_CYCLES;
  localparam logic [CW-1:0]    MULT_LAST = CW'(MULT_ITERS - 1);
  localparam logic [CW-1:0]    DIV_LAST  = CW'(DIV_ITERS - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH:0]   mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             w_start;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  booth_sel_e       w_sel;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_prod;
  logic [WIDTH-1:0] w_mul_lo, w_mul_hi;
  logic             w_mul_exc, w_div_exc;
  logic [RW-1:0]    w_rem_sh, w_rem_nxt;
  logic [WIDTH-1:0] w_quo_signed;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_a_neg = ctrl_signed & data_operandA[WIDTH-1];
  assign w_b_neg = ctrl_signed & data_operandB[WIDTH-1];
  assign w_a_mag = w_a_neg ? -data_operandA : data_operandA;
  assign w_b_mag = w_b_neg ? -data_operandB : data_operandB;

  booth_radix4_enc u_booth (
    .window (mplier_q[2:0]),
    .sel    (w_sel)
  );

  always_comb begin
    w_pp = '0;
    case (w_sel)
      BOOTH_POS1: w_pp = mcand_q;
      BOOTH_POS2: w_pp = mcand_q << 1;
      BOOTH_NEG1: w_pp = -mcand_q;
      BOOTH_NEG2: w_pp = -(mcand_q << 1);
      default:    w_pp = '0;
    endcase
  end

  // Booth treats the multiplier as signed; an unsigned multiplier with its
  // top bit set is worth 2^WIDTH * multiplicand more.
  assign w_prod    = acc_q + ((~sgn_q & b_q[WIDTH-1]) ? {a_q, {WIDTH{1'b0}}} : '0);
  assign w_mul_lo  = w_prod[WIDTH-1:0];
  assign w_mul_hi  = w_prod[PW-1:WIDTH];
  assign w_mul_exc = sgn_q ? (w_mul_hi != {WIDTH{w_mul_lo[WIDTH-1]}}) : (w_mul_hi != '0);

  assign w_rem_sh  = {rem_q[RW-2:0], quo_q[WIDTH-1]};
  assign w_rem_nxt = rem_q[RW-1] ? (w_rem_sh + {2'b00, dvsr_q}) : (w_rem_sh - {2'b00, dvsr_q});

  assign w_div_exc    = sgn_q & (a_q == MIN_NEG) & (b_q == '1);
  assign w_quo_signed = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    exc_d    = exc_q;

    if (w_start) begin
      a_d      = data_operandA;
      b_d      = data_operandB;
      sgn_d    = ctrl_signed;
      neg_a_d  = w_a_neg;
      neg_b_d  = w_b_neg;
      acc_d    = '0;
      rem_d    = '0;
      result_d = '0;
      exc_d    = 1'b0;
      if (ctrl_MULT) begin
        op_d     = OP_MULT;
        state_d  = ST_MULT;
        cnt_d    = MULT_LAST;
        mcand_d  = ctrl_signed ? {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA}
                               : {{WIDTH{1'b0}}, data_operandA};
        mplier_d = {data_operandB, 1'b0};
      end else if (data_operandB == '0) begin
        op_d    = OP_DIV;
        state_d = ST_DONE;
        exc_d   = 1'b1;
      end else begin
        op_d    = OP_DIV;
        state_d = ST_DIV;
        cnt_d   = DIV_LAST;
        quo_d   = w_a_mag;
        dvsr_d  = w_b_mag;
      end
    end else begin
      case (state_q)
        ST_MULT: begin
          acc_d    = acc_q + w_pp;
          mcand_d  = mcand_q << 2;
          mplier_d = mplier_q >> 2;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = ST_FIX;
        end
        ST_DIV: begin
          rem_d = w_rem_nxt;
          quo_d = {quo_q[WIDTH-2:0], ~w_rem_nxt[RW-1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_DONE;
          if (op_q == OP_MULT) begin
            exc_d    = w_mul_exc;
            result_d = w_mul_exc ? '0 : w_mul_lo;
          end else begin
            exc_d    = w_div_exc;
            result_d = w_div_exc ? '0 : w_quo_signed;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

`ifdef MULTDIV_N_HI_RESULT_EN
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [WIDTH-1:0] w_rem_mag, w_rem_signed;

  // Final non-restoring correction only needs the low WIDTH bits.
  assign w_rem_mag    = rem_q[RW-1] ? (rem_q[WIDTH-1:0] + dvsr_q) : rem_q[WIDTH-1:0];
  assign w_rem_signed = neg_a_q ? -w_rem_mag : w_rem_mag;

  always_comb begin
    result_hi_d = result_hi_q;
    if (w_start) begin
      result_hi_d = '0;
    end else if (state_q == ST_FIX) begin
      if (op_q == OP_MULT) result_hi_d = w_mul_hi;
      else                 result_hi_d = w_div_exc ? '0 : w_rem_signed;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) result_hi_q <= '0;
    else       result_hi_q <= result_hi_d;
  end

  assign data_result_hi = result_hi_q;
`else
  assign data_result_hi = '0;
`endif

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q == ST_MULT) || (state_q == ST_DIV) || (state_q == ST_FIX);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_n.sv
`default_nettype none
// =============================================================================
// Module   : tb_multdiv_n
// Brief    : Directed self-checking bench for multdiv_n (WIDTH=32 and WIDTH=8).
// Revision : 1.0  initial release
// =============================================================================
module tb_multdiv_n;

`ifdef MULTDIV_N_HI_RESULT_EN
  localparam bit HI_ON = 1'b1;
`else
  localparam bit HI_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a32, b32, r32, h32;
  logic        m32, d32, s32, e32, y32, bz32;
  logic [7:0]  a8, b8, r8, h8;
  logic        m8, d8, s8, e8, y8, bz8;

  int n_total = 0;
  int n_bad   = 0;
  int lat;
  int cnt;

  always #5 clk = ~clk;

  multdiv_n #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .data_operandA(a32), .data_operandB(b32),
    .ctrl_MULT(m32), .ctrl_DIV(d32), .ctrl_signed(s32),
    .data_result(r32), .data_result_hi(h32), .data_exception(e32),
    .data_resultRDY(y32), .busy(bz32)
  );

  multdiv_n #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst), .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(m8), .ctrl_DIV(d8), .ctrl_signed(s8),
    .data_result(r8), .data_result_hi(h8), .data_exception(e8),
    .data_resultRDY(y8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hx32(input logic [31:0] v);
    return HI_ON ? v : 32'h0;
  endfunction

  function automatic logic [7:0] hx8(input logic [7:0] v);
    return HI_ON ? v : 8'h0;
  endfunction

  // Caller must be just past a negedge; the start cycle ends at the next posedge.
  task automatic kick32(input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    a32 = a; b32 = b; m32 = m; d32 = d; s32 = s;
    @(posedge clk);
    #1;
    m32 = 1'b0; d32 = 1'b0;
  endtask

  task automatic wait32(output int l);
    l = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (y32) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic op32(input logic m, input logic d, input logic s,
                      input logic [31:0] a, input logic [31:0] b, output int l);
    @(negedge clk);
    kick32(m, d, s, a, b);
    wait32(l);
  endtask

  task automatic op8(input logic m, input logic d, input logic s,
                     input logic [7:0] a, input logic [7:0] b, output int l);
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; d8 = d; s8 = s;
    @(posedge clk);
    #1;
    m8 = 1'b0; d8 = 1'b0;
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (y8) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic count_rdy32(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (y32) n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a32 = '0; b32 = '0; m32 = 1'b0; d32 = 1'b0; s32 = 1'b0;
    a8  = '0; b8  = '0; m8  = 1'b0; d8  = 1'b0; s8  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", r32, 0);
    check("rst_hi",     h32, 0);
    check("rst_exc",    e32, 0);
    check("rst_rdy",    y32, 0);
    check("rst_busy",   bz32, 0);
    check("rst8_busy",  bz8, 0);
    rst = 1'b0;

    // signed 7 * -3
    op32(1, 0, 1, 32'd7, 32'hFFFF_FFFD, lat);
    check("smul_lat",  lat, 18);
    check("smul_res",  r32, 32'hFFFF_FFEB);
    check("smul_hi",   h32, hx32(32'hFFFF_FFFF));
    check("smul_exc",  e32, 0);
    check("smul_busy_done", bz32, 0);
    repeat (3) @(negedge clk);
    check("hold_res",  r32, 32'hFFFF_FFEB);
    check("hold_rdy",  y32, 0);

    // busy through a multiply
    @(negedge clk);
    kick32(1, 0, 0, 32'd3, 32'd5);
    @(negedge clk);
    check("busy_mult", bz32, 1);
    wait32(lat);
    check("busy_lat",  lat, 17);
    check("umul_small", r32, 32'd15);

    // signed -100 / 7
    op32(0, 1, 1, 32'hFFFF_FF9C, 32'd7, lat);
    check("sdiv_lat", lat, 34);
    check("sdiv_res", r32, 32'hFFFF_FFF2);
    check("sdiv_hi",  h32, hx32(32'hFFFF_FFFE));
    check("sdiv_exc", e32, 0);

    // unsigned 0xFFFFFFFF * 2
    op32(1, 0, 0, 32'hFFFF_FFFF, 32'd2, lat);
    check("umul_ov_lat", lat, 18);
    check("umul_ov_res", r32, 0);
    check("umul_ov_hi",  h32, hx32(32'd1));
    check("umul_ov_exc", e32, 1);

    // 5 / 0
    op32(0, 1, 0, 32'd5, 32'd0, lat);
    check("dz_lat", lat, 1);
    check("dz_exc", e32, 1);
    check("dz_res", r32, 0);
    check("dz_hi",  h32, 0);

    // signed 0x40000000 * 4
    op32(1, 0, 1, 32'h4000_0000, 32'd4, lat);
    check("smul_ov_exc", e32, 1);
    check("smul_ov_res", r32, 0);
    check("smul_ov_hi",  h32, hx32(32'd1));

    // unsigned 1 * 0xFFFFFFFF (multiplier top bit set)
    op32(1, 0, 0, 32'd1, 32'hFFFF_FFFF, lat);
    check("umul_msb_res", r32, 32'hFFFF_FFFF);
    check("umul_msb_hi",  h32, 0);
    check("umul_msb_exc", e32, 0);

    // signed min * min = 2^62
    op32(1, 0, 1, 32'h8000_0000, 32'h8000_0000, lat);
    check("smul_min_exc", e32, 1);
    check("smul_min_hi",  h32, hx32(32'h4000_0000));

    // unsigned 0xFFFFFFFF / 16
    op32(0, 1, 0, 32'hFFFF_FFFF, 32'd16, lat);
    check("udiv_lat", lat, 34);
    check("udiv_res", r32, 32'h0FFF_FFFF);
    check("udiv_hi",  h32, hx32(32'hF));

    // signed 100 / -7 and -7 / 2
    op32(0, 1, 1, 32'd100, 32'hFFFF_FFF9, lat);
    check("sdiv2_res", r32, 32'hFFFF_FFF2);
    check("sdiv2_hi",  h32, hx32(32'd2));
    op32(0, 1, 1, 32'hFFFF_FFF9, 32'd2, lat);
    check("sdiv3_res", r32, 32'hFFFF_FFFD);
    check("sdiv3_hi",  h32, hx32(32'hFFFF_FFFF));

    // WIDTH=8: signed -128 / -1, unsigned 200 / 7, signed 7 * -3
    op8(0, 1, 1, 8'h80, 8'hFF, lat);
    check("w8_sdiv_lat", lat, 10);
    check("w8_sdiv_exc", e8, 1);
    check("w8_sdiv_res", r8, 0);
    check("w8_sdiv_hi",  h8, 0);
    op8(0, 1, 0, 8'd200, 8'd7, lat);
    check("w8_udiv_lat", lat, 10);
    check("w8_udiv_res", r8, 8'd28);
    check("w8_udiv_hi",  h8, hx8(8'd4));
    check("w8_udiv_exc", e8, 0);
    op8(1, 0, 1, 8'd7, 8'hFD, lat);
    check("w8_smul_lat", lat, 6);
    check("w8_smul_res", r8, 8'hEB);
    check("w8_smul_hi",  h8, hx8(8'hFF));

    // reset in the middle of a divide
    @(negedge clk);
    kick32(0, 1, 0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    check("mid_busy", bz32, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_res",  r32, 0);
    check("mid_rst_hi",   h32, 0);
    check("mid_rst_exc",  e32, 0);
    check("mid_rst_rdy",  y32, 0);
    check("mid_rst_busy", bz32, 0);
    count_rdy32(40, cnt);
    check("mid_rst_no_rdy", cnt, 0);

    // abort a divide with a multiply at cycle 5
    @(negedge clk);
    kick32(0, 1, 0, 32'd1000, 32'd3);
    count_rdy32(4, cnt);
    check("abort_pre_rdy", cnt, 0);
    kick32(1, 0, 1, 32'd7, 32'hFFFF_FFFD);
    wait32(lat);
    check("abort_lat", lat, 18);
    check("abort_res", r32, 32'hFFFF_FFEB);
    count_rdy32(40, cnt);
    check("abort_no_div_rdy", cnt, 0);

    // new start in the DONE cycle
    op32(1, 0, 0, 32'd6, 32'd7, lat);
    check("b2b_mul_lat", lat, 18);
    check("b2b_mul_res", r32, 32'd42);
    kick32(0, 1, 0, 32'd50, 32'd5);
    wait32(lat);
    check("b2b_div_lat", lat, 34);
    check("b2b_div_res", r32, 32'd10);
    check("b2b_div_hi",  h32, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
